// File: rtl/datapath_pkg.sv
// Shared types for the datapath control sequencer: opcodes, ALU function codes
// and the control word that drives the datapath for one cycle.
package datapath_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_CLR   = 3'd1,
      OP_MOVM  = 3'd2,
      OP_MOVRM = 3'd3,
      OP_MOVRA = 3'd4,
      OP_MOVAR = 3'd5,
      OP_ADC   = 3'd6,
      OP_SBC   = 3'd7
   } op_e;

   localparam logic [2:0] ALU_ADC   = 3'b000;
   localparam logic [2:0] ALU_SBC   = 3'b001;
   localparam logic [2:0] ALU_PASSB = 3'b010;

   typedef struct packed {
      logic       clr;
      logic [3:0] ce;
      logic [2:0] w;
      logic [1:0] sel;
      logic [2:0] s;
   } ctrl_word_t;

   localparam ctrl_word_t IDLE_WORD = '0;

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

endpackage

// File: rtl/datapath_decoder.sv
// Combinational instruction decoder: instr -> control word, illegal and halt flags.
module datapath_decoder
   import datapath_pkg::*;
(
   input  logic [7:0] instr_i,
   output ctrl_word_t word_o,
   output logic       illegal_o,
   output logic       halt_o
);

   op_e        op;
   logic [1:0] dst;
   logic [1:0] src;
   logic       rsvd;

   assign op   = op_e'(instr_i[7:5]);
   assign dst  = instr_i[4:3];
   assign rsvd = instr_i[2];
   assign src  = instr_i[1:0];

   always_comb begin
      word_o    = IDLE_WORD;
      illegal_o = rsvd;
      halt_o    = 1'b0;
      case (op)
         OP_NOP:   halt_o = (dst == 2'b11);
         OP_CLR:   word_o.clr = 1'b1;
         OP_MOVM:  word_o.ce = 4'b0111;
         OP_MOVRM: begin
            if (dst == 2'b11) illegal_o = 1'b1;
            word_o.ce = {1'b0, onehot3(dst)};
         end
         OP_MOVRA: begin
            if (dst == 2'b11) illegal_o = 1'b1;
            word_o.ce = {1'b0, onehot3(dst)};
            word_o.w  = onehot3(dst);
         end
         OP_MOVAR, OP_ADC, OP_SBC: begin
            if (src == 2'b11) illegal_o = 1'b1;
            word_o.ce  = 4'b1000;
            word_o.sel = src;
            word_o.s   = (op == OP_MOVAR) ? ALU_PASSB :
                         (op == OP_ADC)   ? ALU_ADC   : ALU_SBC;
         end
      endcase
      // An illegal encoding never drives the datapath and never halts.
      if (illegal_o) begin
         word_o = IDLE_WORD;
         halt_o = 1'b0;
      end
   end

endmodule

// File: rtl/datapath_ctrl.sv
// Control sequencer: accepts instructions over valid/ready and issues one registered
// control word per accepted instruction, with HALT/resume, sticky error and retire count.
module datapath_ctrl
   import datapath_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic [7:0]       instr_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             resume_i,
   output logic             clr_o,
   output logic [3:0]       ce_o,
   output logic [2:0]       w_o,
   output logic [1:0]       sel_o,
   output logic [2:0]       s_o,
   output logic             halted_o,
   output logic             err_o,
   output logic [CNT_W-1:0] retired_o
);

   localparam logic ST_RUN    = 1'b0;
   localparam logic ST_HALTED = 1'b1;

   // Handshake: an instruction transfers on a rising edge where valid_i and ready_o are
   // both high; upstream holds instr_i stable while valid_i is high and ready_o is low.
   logic             state_q, state_d;
   ctrl_word_t       word_q, word_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   ctrl_word_t       dec_word;
   logic             dec_illegal, dec_halt;
   logic             accept;

   datapath_decoder u_decoder (
      .instr_i   (instr_i),
      .word_o    (dec_word),
      .illegal_o (dec_illegal),
      .halt_o    (dec_halt)
   );

   assign ready_o = ~clr_i & (state_q == ST_RUN);
   assign accept  = valid_i & ready_o;

   always_comb begin
      state_d   = state_q;
      word_d    = IDLE_WORD;
      err_d     = err_q;
      retired_d = retired_q;
      if (accept) begin
         word_d = dec_word;
         if (dec_illegal) err_d = 1'b1;
         if (dec_halt) state_d = ST_HALTED;
         else          retired_d = retired_q + 1'b1;
      end else if (state_q == ST_HALTED && resume_i) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         state_q   <= ST_RUN;
         word_q    <= IDLE_WORD;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         err_q     <= err_d;
         retired_q <= retired_d;
      end
   end

   // clr_i masks the live word so a pending instruction never reaches the datapath.
   assign clr_o     = word_q.clr & ~clr_i;
   assign ce_o      = word_q.ce  & {4{~clr_i}};
   assign w_o       = word_q.w   & {3{~clr_i}};
   assign sel_o     = word_q.sel & {2{~clr_i}};
   assign s_o       = word_q.s   & {3{~clr_i}};
   assign halted_o  = (state_q == ST_HALTED);
   assign err_o     = err_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: decode table, directed multi-cycle sequences against a small
// behavioural datapath, and a randomized stream checked by a reference model.
module tb_datapath_ctrl;

   logic       clk = 1'b0;
   logic       clr_i, valid_i, ready_o, resume_i;
   logic [7:0] instr_i;
   logic       clr_o;
   logic [3:0] ce_o;
   logic [2:0] w_o, s_o;
   logic [1:0] sel_o;
   logic       halted_o, err_o;
   logic [7:0] retired_o;
   logic [12:0] act_word;

   datapath_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .clr_i(clr_i), .instr_i(instr_i), .valid_i(valid_i), .ready_o(ready_o),
      .resume_i(resume_i), .clr_o(clr_o), .ce_o(ce_o), .w_o(w_o), .sel_o(sel_o), .s_o(s_o),
      .halted_o(halted_o), .err_o(err_o), .retired_o(retired_o)
   );

   always #5 clk = ~clk;
   assign act_word = {clr_o, ce_o, w_o, sel_o, s_o};

   // Behavioural datapath: M0=3, M1=A, M2=0, Cin=1, 4-bit registers.
   logic [3:0] dp_r [3];
   logic [3:0] dp_a;
   logic [3:0] dp_m [3];
   logic [3:0] dp_b, dp_alu;
   initial begin
      dp_m[0] = 4'h3; dp_m[1] = 4'hA; dp_m[2] = 4'h0;
   end
   always_comb begin
      dp_b = (sel_o == 2'd0) ? dp_r[0] : (sel_o == 2'd1) ? dp_r[1] : dp_r[2];
      case (s_o)
         3'b000:  dp_alu = dp_a + dp_b + 4'd1;
         3'b001:  dp_alu = dp_a + ~dp_b + 4'd1;
         3'b010:  dp_alu = dp_b;
         default: dp_alu = dp_a;
      endcase
   end
   always @(posedge clk) begin
      if (clr_o) begin
         for (int i = 0; i < 3; i++) dp_r[i] <= 4'h0;
         dp_a <= 4'h0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (ce_o[i]) dp_r[i] <= w_o[i] ? dp_a : dp_m[i];
         if (ce_o[3]) dp_a <= dp_alu;
      end
   end

   // Scoreboard and reference model state.
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [12:0] exp_q[$];
   bit m_halted = 0;
   bit m_err    = 0;
   int m_ret    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the instruction-set rules.
   function automatic void ref_dec(input logic [7:0] ins, output logic [12:0] w,
                                   output bit ill, output bit hlt);
      int op, dst, src;
      logic       f_clr;
      logic [3:0] f_ce;
      logic [2:0] f_w, f_s;
      logic [1:0] f_sel;
      op  = int'(ins[7:5]);
      dst = int'(ins[4:3]);
      src = int'(ins[1:0]);
      f_clr = 0; f_ce = 0; f_w = 0; f_sel = 0; f_s = 0;
      ill = ins[2] || (dst == 3 && (op == 3 || op == 4)) || (src == 3 && op >= 5);
      hlt = !ill && op == 0 && dst == 3;
      if (!ill) begin
         if (op == 1) f_clr = 1;
         if (op == 2) f_ce = 4'b0111;
         if (op == 3 || op == 4) f_ce = 4'b0001 << dst;
         if (op == 4) f_w = 3'b001 << dst;
         if (op >= 5) begin
            f_ce  = 4'b1000;
            f_sel = ins[1:0];
            f_s   = (op == 5) ? 3'b010 : (op == 6) ? 3'b000 : 3'b001;
         end
      end
      w = {f_clr, f_ce, f_w, f_sel, f_s};
   endfunction

   // One clock cycle, starting and ending at a falling edge.
   task automatic cycle(input logic v, input logic [7:0] ins, input logic res, input logic rst);
      logic [12:0] w;
      bit ill, hlt, exp_rdy, acc;
      valid_i = v; instr_i = ins; resume_i = res; clr_i = rst;
      #1;
      exp_rdy = !rst && !m_halted;
      chk("ready", ready_o, exp_rdy);
      if (rst) chk("rst_gate", act_word, 0);
      acc = v && exp_rdy;
      if (rst) begin
         m_halted = 0; m_err = 0; m_ret = 0;
         exp_q.push_back(13'h0);
      end else if (acc) begin
         ref_dec(ins, w, ill, hlt);
         exp_q.push_back(w);
         if (ill) m_err = 1;
         if (hlt) m_halted = 1;
         else     m_ret = (m_ret + 1) % 256;
      end else begin
         exp_q.push_back(13'h0);
         if (m_halted && res) m_halted = 0;
      end
      @(posedge clk); #1;
      chk("word", act_word, exp_q.pop_front());
      chk("halted", halted_o, m_halted);
      chk("err", err_o, m_err);
      chk("retired", retired_o, m_ret);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  instr;
      logic [12:0] word;
      bit          ill;
      bit          hlt;
   } vec_t;
   vec_t vecs[12];

   initial begin
      vecs[0]  = '{8'h00, 13'b0_0000_000_00_000, 0, 0};
      vecs[1]  = '{8'h20, 13'b1_0000_000_00_000, 0, 0};
      vecs[2]  = '{8'h40, 13'b0_0111_000_00_000, 0, 0};
      vecs[3]  = '{8'h68, 13'b0_0010_000_00_000, 0, 0};
      vecs[4]  = '{8'h90, 13'b0_0100_100_00_000, 0, 0};
      vecs[5]  = '{8'hA2, 13'b0_1000_000_10_010, 0, 0};
      vecs[6]  = '{8'hC1, 13'b0_1000_000_01_000, 0, 0};
      vecs[7]  = '{8'hE0, 13'b0_1000_000_00_001, 0, 0};
      vecs[8]  = '{8'h78, 13'b0_0000_000_00_000, 1, 0};
      vecs[9]  = '{8'h24, 13'b0_0000_000_00_000, 1, 0};
      vecs[10] = '{8'hA3, 13'b0_0000_000_00_000, 1, 0};
      vecs[11] = '{8'h18, 13'b0_0000_000_00_000, 0, 1};

      clr_i = 1; valid_i = 0; instr_i = 0; resume_i = 0;
      @(negedge clk);
      cycle(0, 8'h00, 0, 1);
      chk("reset_retired", retired_o, 0);

      // Decode table.
      for (int i = 0; i < 12; i++) begin
         cycle(0, 8'h00, 0, 1);
         cycle(1, vecs[i].instr, 0, 0);
         chk("tbl_word", act_word, vecs[i].word);
         chk("tbl_err", err_o, vecs[i].ill);
         chk("tbl_halt", halted_o, vecs[i].hlt);
      end

      // Back-to-back program.
      cycle(0, 8'h00, 0, 1);
      cycle(1, 8'h20, 0, 0);
      cycle(1, 8'h40, 0, 0);
      cycle(1, 8'hA0, 0, 0);
      cycle(1, 8'hE1, 0, 0);
      cycle(1, 8'h90, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s1_r0", dp_r[0], 4'h3);
      chk("s1_r1", dp_r[1], 4'hA);
      chk("s1_r2", dp_r[2], 4'h9);
      chk("s1_a", dp_a, 4'h9);
      chk("s1_ret", retired_o, 5);
      chk("s1_err", err_o, 0);

      // HALT with a held instruction, then resume.
      cycle(1, 8'h18, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 8'h40, 0, 0);
      chk("s2_halted", halted_o, 1);
      chk("s2_r2_hold", dp_r[2], 4'h9);
      cycle(1, 8'h40, 1, 0);
      chk("s2_resumed", halted_o, 0);
      cycle(1, 8'h40, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s2_ret", retired_o, 6);
      chk("s2_r2_load", dp_r[2], 4'h0);

      // Illegal instructions.
      cycle(1, 8'h98, 0, 0);
      cycle(1, 8'hE3, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s3_err", err_o, 1);
      chk("s3_ret", retired_o, 8);
      cycle(1, 8'h20, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s3_sticky", err_o, 1);

      // ADC with a valid gap.
      cycle(0, 8'h00, 0, 1);
      cycle(1, 8'h20, 0, 0);
      cycle(1, 8'h40, 0, 0);
      cycle(1, 8'hC0, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s4_a1", dp_a, 4'h4);
      chk("s4_gap", act_word, 0);
      cycle(1, 8'hC0, 0, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s4_a2", dp_a, 4'h8);

      // clr_i right after an accept drops the pending word.
      cycle(1, 8'h20, 0, 0);
      cycle(1, 8'h40, 0, 0);
      cycle(0, 8'h00, 0, 1);
      chk("s5_r0", dp_r[0], 4'h0);
      chk("s5_ret", retired_o, 0);
      chk("s5_err", err_o, 0);
      cycle(0, 8'h00, 0, 0);
      chk("s5_r0_after", dp_r[0], 4'h0);

      // Counter wrap.
      for (int i = 0; i < 255; i++) cycle(1, 8'h00, 0, 0);
      chk("s6_max", retired_o, 255);
      cycle(1, 8'h00, 0, 0);
      chk("s6_wrap", retired_o, 0);

      // Randomized stream.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
